// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter.
// Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out
// LSB first, one bit per clock. A new word can be accepted during the final
// bit cycle of the current one, so consecutive words leave with no idle gap.
// Bit order matches a downstream right-shifting SIPO: data_in[0] ends up in
// the SIPO's out[0] after the last shift.
module piso_tx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             last
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] shreg_r;
    logic [CW-1:0]    cnt_r;
    logic             cnt_at_max_s;
    logic             accept_s;

    // Shared decode: counter sitting on the final bit, and handshake completion.
    always_comb begin
        cnt_at_max_s = (cnt_r == CNT_MAX);
        accept_s     = in_valid && in_ready;
    end

    // State register; reset drops any word in flight immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: stay in SHIFT across words when a new one is accepted on the last bit.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_at_max_s && !accept_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state only; nothing here depends on inputs.
    always_comb begin
        in_ready   = 1'b0;
        sout       = 1'b0;
        sout_valid = 1'b0;
        last       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_SHIFT: begin
                in_ready   = cnt_at_max_s;
                sout       = shreg_r[0];
                sout_valid = 1'b1;
                last       = cnt_at_max_s;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Datapath: load on accept, otherwise shift right with zero fill until the last bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_r <= '0;
            cnt_r   <= '0;
        end else if (accept_s) begin
            shreg_r <= data_in;
            cnt_r   <= '0;
        end else if ((state_r == ST_SHIFT) && !cnt_at_max_s) begin
            shreg_r <= {1'b0, shreg_r[WIDTH-1:1]};
            cnt_r   <= cnt_r + CW'(1);
        end else if (state_r == ST_SHIFT) begin
            // Word finished with nothing queued: park the datapath cleared.
            shreg_r <= '0;
            cnt_r   <= '0;
        end else begin
            shreg_r <= shreg_r;
            cnt_r   <= cnt_r;
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: a WIDTH=4 instance chained into a 4-bit SIPO
// model, plus a WIDTH=8 instance. Inputs change and outputs are sampled on
// the falling clock edge; the DUT acts on the rising edge.
module tb_piso_tx;

    logic       clk;
    logic       rst;
    logic [3:0] d4;
    logic       v4;
    logic       rdy4;
    logic       so4;
    logic       sv4;
    logic       last4;
    logic [7:0] d8;
    logic       v8;
    logic       rdy8;
    logic       so8;
    logic       sv8;
    logic       last8;
    logic [3:0] sipo;

    int checks;
    int errors;

    piso_tx #(.WIDTH(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .data_in    (d4),
        .in_valid   (v4),
        .in_ready   (rdy4),
        .sout       (so4),
        .sout_valid (sv4),
        .last       (last4)
    );

    piso_tx #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .data_in    (d8),
        .in_valid   (v8),
        .in_ready   (rdy8),
        .sout       (so8),
        .sout_valid (sv8),
        .last       (last8)
    );

    // Clock: 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream SIPO: shifts every clock, new bit enters at the MSB.
    always @(posedge clk or negedge rst) begin
        if (!rst) sipo <= 4'h0;
        else      sipo <= {so4, sipo[3:1]};
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Checks one bit cycle of the 4-bit instance: bit k of word w.
    task automatic bit4(input string tag, input logic [3:0] w, input int k);
        logic exp_last;
        exp_last = (k == 3);
        chk({tag, "_sout"}, {7'd0, so4}, {7'd0, w[k]});
        chk({tag, "_valid"}, {7'd0, sv4}, 8'd1);
        chk({tag, "_last"}, {7'd0, last4}, {7'd0, exp_last});
        chk({tag, "_ready"}, {7'd0, rdy4}, {7'd0, exp_last});
    endtask

    task automatic idle4(input string tag);
        chk({tag, "_sout"}, {7'd0, so4}, 8'd0);
        chk({tag, "_valid"}, {7'd0, sv4}, 8'd0);
        chk({tag, "_last"}, {7'd0, last4}, 8'd0);
        chk({tag, "_ready"}, {7'd0, rdy4}, 8'd1);
    endtask

    initial begin
        logic [3:0] w;
        logic [7:0] w8;
        checks = 0;
        errors = 0;
        rst = 1'b0;
        d4  = 4'h0;
        v4  = 1'b0;
        d8  = 8'h00;
        v8  = 1'b0;

        // Reset held with random inputs: both instances must stay idle.
        for (int i = 0; i < 4; i++) begin
            d4 = 4'($urandom);
            v4 = 1'($urandom);
            d8 = 8'($urandom);
            v8 = 1'($urandom);
            cyc();
            idle4("rst4");
            chk("rst8_valid", {7'd0, sv8}, 8'd0);
            chk("rst8_sout", {7'd0, so8}, 8'd0);
            chk("rst8_last", {7'd0, last8}, 8'd0);
            chk("rst8_ready", {7'd0, rdy8}, 8'd1);
        end
        v4 = 1'b0;
        v8 = 1'b0;
        rst = 1'b1;
        cyc();
        idle4("post_rst_a");
        cyc();
        idle4("post_rst_b");

        // Single word 1011 followed by idle; SIPO holds the word afterwards.
        w  = 4'hB;
        d4 = w;
        v4 = 1'b1;
        cyc();
        v4 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bit4("single", w, k);
            if (k < 3) cyc();
        end
        cyc();
        idle4("single_after");
        chk("single_sipo", {4'd0, sipo}, 8'h0B);

        // Back-to-back A then 5 with no gap.
        w  = 4'hA;
        d4 = w;
        v4 = 1'b1;
        cyc();
        for (int k = 0; k < 4; k++) begin
            bit4("b2b_a", w, k);
            if (k == 3) d4 = 4'h5;
            cyc();
        end
        w  = 4'h5;
        v4 = 1'b0;
        chk("b2b_sipo_a", {4'd0, sipo}, 8'h0A);
        for (int k = 0; k < 4; k++) begin
            bit4("b2b_5", w, k);
            if (k < 3) cyc();
        end
        cyc();
        idle4("b2b_after");
        chk("b2b_sipo_5", {4'd0, sipo}, 8'h05);

        // Stall: F presented mid-word is ignored until the last-bit edge.
        w  = 4'h6;
        d4 = w;
        v4 = 1'b1;
        cyc();
        v4 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bit4("stall_6", w, k);
            if (k == 1) begin
                d4 = 4'hF;
                v4 = 1'b1;
            end
            cyc();
        end
        v4 = 1'b0;
        w  = 4'hF;
        for (int k = 0; k < 4; k++) begin
            bit4("stall_f", w, k);
            if (k < 3) cyc();
        end
        cyc();
        idle4("stall_after");
        chk("stall_sipo", {4'd0, sipo}, 8'h0F);

        // Async reset in the second bit cycle of C aborts the word at once.
        w  = 4'hC;
        d4 = w;
        v4 = 1'b1;
        cyc();
        v4 = 1'b0;
        bit4("arst_c0", w, 0);
        cyc();
        bit4("arst_c1", w, 1);
        #1 rst = 1'b0;
        #1;
        idle4("arst_now");
        cyc();
        idle4("arst_held");
        rst = 1'b1;
        cyc();
        idle4("arst_rel");
        w  = 4'h3;
        d4 = w;
        v4 = 1'b1;
        cyc();
        v4 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bit4("arst_3", w, k);
            if (k < 3) cyc();
        end
        cyc();
        idle4("arst_after");
        chk("arst_sipo", {4'd0, sipo}, 8'h03);

        // WIDTH=8 instance: 96 goes out as 0,1,1,0,1,0,0,1.
        w8 = 8'h96;
        d8 = w8;
        v8 = 1'b1;
        chk("w8_ready_idle", {7'd0, rdy8}, 8'd1);
        cyc();
        v8 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("w8_sout", {7'd0, so8}, {7'd0, w8[k]});
            chk("w8_valid", {7'd0, sv8}, 8'd1);
            chk("w8_last", {7'd0, last8}, {7'd0, (k == 7)});
            cyc();
        end
        chk("w8_after_valid", {7'd0, sv8}, 8'd0);
        chk("w8_after_last", {7'd0, last8}, 8'd0);
        chk("w8_after_ready", {7'd0, rdy8}, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
- Parallel-in serial-out transmitter: the upstream stage that feeds the 4-bit SIPO register.
- Accepts a WIDTH-bit word through a valid/ready handshake and drives it out one bit per clock, LSB first.
- Bit order is chosen so that the downstream SIPO holds the word unchanged: data_in[0] lands in out[0] after the last shift.
- Supports gapless back-to-back words.

Parameters:
- WIDTH, 4, word width in bits; legal range WIDTH >= 2. Counter width is clog2(WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-low.
- data_in  input  WIDTH  parallel word to transmit; sampled only on an accept edge.
- in_valid  input  1  upstream asserts when data_in is valid.
- in_ready  output  1  block can accept a word this cycle.
- sout  output  1  serial data out; connects to the SIPO serial input.
- sout_valid  output  1  high on every cycle that sout carries a payload bit.
- last  output  1  high during the final bit cycle of a word.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, shift register=0, bit counter=0.
  - sout=0, sout_valid=0, last=0, in_ready=1.
  - A reset mid-word aborts immediately and the word is lost. No partial bits appear after rst is released.
- States:
  - IDLE: nothing in flight.
  - SHIFT: word in flight; counter cnt goes 0..WIDTH-1.
- in_ready (combinational from state) = (state==IDLE) OR (state==SHIFT AND cnt==WIDTH-1).
- Accept: rising edge with in_valid=1 AND in_ready=1.
  - Effect: shreg<=data_in, cnt<=0, state<=SHIFT.
- SHIFT, cnt<WIDTH-1, each edge: shreg shifts right with zero fill, cnt<=cnt+1.
- SHIFT, cnt==WIDTH-1, each edge:
  - Accept present: new word loads, state stays SHIFT (no idle bubble).
  - No accept: state<=IDLE.
- Outputs (all functions of registered state, no combinational path from inputs):
  - sout = shreg[0] when state==SHIFT, else 0.
  - sout_valid = (state==SHIFT).
  - last = (state==SHIFT AND cnt==WIDTH-1).
- Latency: accept at edge N puts data_in[k] on sout during cycle N+1+k, for k=0..WIDTH-1. last is high during cycle N+WIDTH.
- in_valid while in_ready=0: ignored, data_in not sampled, in-flight word unaffected. Upstream must hold data_in and in_valid until accepted.
- Pairing with the SIPO (WIDTH=4; the SIPO shifts every clock, no enable):
  - SIPO out equals the transmitted word after the edge that ends the last-bit cycle.
  - The consumer samples the SIPO on the cycle after last.
  - In IDLE, sout=0 shifts zeros into the SIPO.
- Arithmetic: cnt never exceeds WIDTH-1; no wrap beyond it.

Test Plan:
- Reset: hold rst=0 with random inputs -> sout=0, sout_valid=0, last=0, in_ready=1. Release rst -> still idle with no activity.
- Single word 4'b1011 accepted at edge N -> sout=1,1,0,1 in cycles N+1..N+4; sout_valid=1 for exactly those 4 cycles; last=1 only in N+4; idle after. Chained SIPO shows out=4'b1011 the following cycle.
- Back-to-back 4'hA then 4'h5, in_valid held high:
  - 8 contiguous valid cycles with sout=0,1,0,1,1,0,1,0.
  - in_ready=1 only in the two last-bit cycles (plus initial idle).
  - last pulses twice; no gap between words.
- Stall rejection: word 4'h6 in flight; assert in_valid with data_in=4'hF at cnt=1 -> no accept, in_ready=0, sout continues 0,1,1,0. 4'hF is accepted at the last-bit edge and transmits 1,1,1,1.
- Async reset mid-word: 4'hC in flight, rst=0 between edges during cycle 2 -> sout, sout_valid and last go 0 before the next edge. After release, 4'h3 transmits 1,1,0,0 correctly.
- WIDTH=8 instance: accept 8'h96 -> sout=0,1,1,0,1,0,0,1 over 8 cycles; last in the 8th cycle only.
